// File: rtl/keypad_entry_ctrl_pkg.sv
// keypad_pkg: key codes, scan FSM states and the row/column to key-code map
package keypad_pkg;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;
   typedef enum logic [1:0] {ST_SCAN, ST_DB_PRESS, ST_HELD, ST_DB_REL} scan_state_e;
   localparam logic [15:0][3:0] KEYMAP = {
      KEY_D, KEY_HASH, 4'h0, KEY_STAR,
      KEY_C, 4'h9,     4'h8, 4'h7,
      KEY_B, 4'h6,     4'h5, 4'h4,
      KEY_A, 4'h3,     4'h2, 4'h1
   };
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      return !v[1] ? 2'd1 : !v[2] ? 2'd2 : !v[3] ? 2'd3 : 2'd0;
   endfunction
   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      return KEYMAP[{row, col}];
   endfunction
endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: keypad pins plus the entered-number bus towards the consumer
interface keypad_entry_ctrl_if;
   logic [3:0]  line;
   logic [3:0]  col;
   logic [3:0]  reg1;
   logic [3:0]  reg2;
   logic [3:0]  reg3;
   logic [3:0]  reg4;
   logic [2:0]  digit_count;
   logic        entry_valid;
   logic [15:0] entry_value;
   logic [2:0]  entry_len;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        err;
   modport master (input line, output col, reg1, reg2, reg3, reg4, digit_count,
                   entry_valid, entry_value, entry_len, key_valid, key_code, err);
   modport slave (output line, input col, reg1, reg2, reg3, reg4, digit_count,
                  entry_valid, entry_value, entry_len, key_valid, key_code, err);
endinterface

// File: rtl/keypad_entry_ctrl_scanner.sv
// keypad_scanner: column scan, row synchroniser and press/release debounce
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int DB_CYCLES = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] line,
   output logic [3:0] col,
   output logic       press_done,
   output logic [3:0] press_code
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   scan_state_e   state_q, state_d;
   logic [3:0]    line_m_q, line_s_q, col_q, col_d, snap_q, snap_d, code_q, code_d;
   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          one_low, stay, commit;
   assign one_low = $countones(~line_s_q) == 1;
   // state and datapath registers; rows idle high so the synchroniser resets to 1111
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_SCAN;
         line_m_q <= 4'hF;
         line_s_q <= 4'hF;
         col_q    <= 4'b1110;
         snap_q   <= 4'hF;
         code_q   <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         line_m_q <= line;
         line_s_q <= line_m_q;
         col_q    <= col_d;
         snap_q   <= snap_d;
         code_q   <= code_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
      end
   end
   // next state: a press needs DB_CYCLES matching cycles, a release DB_CYCLES idle cycles
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_SCAN:     state_d = one_low ? ST_DB_PRESS : ST_SCAN;
         ST_DB_PRESS: state_d = line_s_q != snap_q ? ST_SCAN : cnt_q == CNT_LAST ? ST_HELD : ST_DB_PRESS;
         ST_HELD:     state_d = line_s_q == 4'hF ? ST_DB_REL : ST_HELD;
         ST_DB_REL:   state_d = line_s_q != 4'hF ? ST_HELD : cnt_q == CNT_LAST ? ST_SCAN : ST_DB_REL;
      endcase
   end
   // datapath: column only moves while scanning or after a committed release
   always_comb begin
      stay       = state_d == state_q;
      commit     = state_q == ST_DB_REL && state_d == ST_SCAN;
      cnt_d      = (stay && (state_q == ST_DB_PRESS || state_q == ST_DB_REL)) ? cnt_q + 1'b1 : '0;
      div_d      = (stay && state_q == ST_SCAN && div_q != DIV_LAST) ? div_q + 1'b1 : '0;
      col_d      = ((stay && state_q == ST_SCAN && div_q == DIV_LAST) || commit) ? {col_q[2:0], col_q[3]} : col_q;
      snap_d     = (state_q == ST_SCAN && one_low) ? line_s_q : snap_q;
      code_d     = (state_q == ST_DB_PRESS && state_d == ST_HELD) ? keymap(low_idx(snap_q), low_idx(col_q)) : code_q;
      press_done = commit;
      press_code = code_q;
      col        = col_q;
   end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad scanner plus digit-entry sequencer and commit logic
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int DB_CYCLES = 20
) (
   input logic                 clk,
   input logic                 reset,
   keypad_entry_ctrl_if.master bus
);
   logic [3:0]       col, press_code, key_code_q, key_code_d;
   logic             press_done, is_digit;
   logic [0:3][3:0]  regs_q, regs_d;
   logic [2:0]       count_q, count_d, entry_len_q, entry_len_d;
   logic [15:0]      entry_value_q, entry_value_d;
   logic             key_valid_q, key_valid_d, entry_valid_q, entry_valid_d, err_q, err_d;
   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) u_scanner (
      .clk        (clk),
      .reset      (reset),
      .line       (bus.line),
      .col        (col),
      .press_done (press_done),
      .press_code (press_code)
   );
   assign is_digit = !(press_code inside {KEY_A, KEY_B, KEY_C, KEY_D, KEY_STAR, KEY_HASH});
   // entry registers and one-cycle pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q        <= '0;
         count_q       <= '0;
         entry_value_q <= '0;
         entry_len_q   <= '0;
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         entry_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         count_q       <= count_d;
         entry_value_q <= entry_value_d;
         entry_len_q   <= entry_len_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         entry_valid_q <= entry_valid_d;
         err_q         <= err_d;
      end
   end
   // commit a released key: append digit, clear on '*', publish on '#'
   always_comb begin
      regs_d        = regs_q;
      count_d       = count_q;
      entry_value_d = entry_value_q;
      entry_len_d   = entry_len_q;
      key_code_d    = press_done ? press_code : key_code_q;
      key_valid_d   = press_done;
      entry_valid_d = 1'b0;
      err_d         = 1'b0;
      if (press_done) begin
         if (is_digit) begin
            if (count_q == 3'd4) err_d = 1'b1;
            else begin
               regs_d[count_q[1:0]] = press_code;
               count_d              = count_q + 3'd1;
            end
         end else if (press_code == KEY_STAR) begin
            regs_d  = '0;
            count_d = '0;
         end else if (press_code == KEY_HASH) begin
            if (count_q == 3'd0) err_d = 1'b1;
            else begin
               entry_valid_d = 1'b1;
               entry_value_d = regs_q;
               entry_len_d   = count_q;
               regs_d        = '0;
               count_d       = '0;
            end
         end
      end
   end
   // drive the consumer-facing bus
   always_comb begin
      bus.col         = col;
      bus.reg1        = regs_q[0];
      bus.reg2        = regs_q[1];
      bus.reg3        = regs_q[2];
      bus.reg4        = regs_q[3];
      bus.digit_count = count_q;
      bus.entry_valid = entry_valid_q;
      bus.entry_value = entry_value_q;
      bus.entry_len   = entry_len_q;
      bus.key_valid   = key_valid_q;
      bus.key_code    = key_code_q;
      bus.err         = err_q;
   end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed scenarios against a behavioural 4x4 keypad
module tb_keypad_entry_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   keypad_entry_ctrl_if bus();
   logic       pressed = 1'b0;
   logic [1:0] pr = 2'd0, pc = 2'd0;
   logic [3:0] force_line = 4'hF;
   assign bus.line = force_line & ((pressed && bus.col[pc] == 1'b0) ? ~(4'b0001 << pr) : 4'hF);
   keypad_entry_ctrl #(.SCAN_DIV(4), .DB_CYCLES(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   int errors = 0;
   int checks = 0;
   logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                               '{4'h4, 4'h5, 4'h6, 4'hB},
                               '{4'h7, 4'h8, 4'h9, 4'hC},
                               '{4'hE, 4'h0, 4'hF, 4'hD}};
   logic [3:0]  s_code;
   logic        s_err, s_ev;
   logic [15:0] s_eval, s_regs;
   logic [2:0]  s_elen, s_cnt;

   // wait for col to step onto target, so the press lands at the start of its slot
   task automatic wait_col(input logic [3:0] target);
      int n = 0;
      while (bus.col == target && n < 40) begin @(negedge clk); n++; end
      while (bus.col != target && n < 80) begin @(negedge clk); n++; end
      checks++;
      if (bus.col !== target) begin errors++; $display("FAIL wait_col got=%b want=%b", bus.col, target); end
   endtask

   task automatic start_press(input logic [3:0] code);
      logic [3:0] tgt;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (kmap[r][c] == code) begin pr = r[1:0]; pc = c[1:0]; end
      tgt = ~(4'b0001 << pc);
      wait_col(tgt);
      pressed = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic release_key(input logic [3:0] code);
      bit hit = 1'b0;
      pressed = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = bus.key_valid; end
      checks++;
      if (!hit) begin errors++; $display("FAIL key_valid_timeout key=%h got=0 want=1", code); end
      s_code = bus.key_code; s_err = bus.err; s_ev = bus.entry_valid; s_eval = bus.entry_value;
      s_elen = bus.entry_len; s_cnt = bus.digit_count; s_regs = {bus.reg1, bus.reg2, bus.reg3, bus.reg4};
      @(negedge clk);
      checks++;
      if ({bus.key_valid, bus.err, bus.entry_valid} !== 3'b000) begin
         errors++; $display("FAIL pulse_width key=%h got=%b want=000", code, {bus.key_valid, bus.err, bus.entry_valid});
      end
   endtask

   task automatic press_key(input logic [3:0] code);
      start_press(code);
      release_key(code);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b want=1110", bus.col); end
      checks++;
      if ({bus.reg1, bus.reg2, bus.reg3, bus.reg4, bus.digit_count} !== 19'd0) begin
         errors++; $display("FAIL reset_regs got=%h/%0d want=0000/0", {bus.reg1, bus.reg2, bus.reg3, bus.reg4}, bus.digit_count);
      end
      checks++;
      if ({bus.entry_value, bus.entry_len, bus.key_code, bus.key_valid, bus.entry_valid, bus.err} !== 26'd0) begin
         errors++; $display("FAIL reset_outputs got=%h/%0d/%h/%b want=0000/0/0/000", bus.entry_value, bus.entry_len, bus.key_code, {bus.key_valid, bus.entry_valid, bus.err});
      end
      reset = 1'b0;
   endtask

   task automatic test_idle();
      logic [3:0] exp;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         exp = ~(4'b0001 << ((n / 4) % 4));
         checks++;
         if (bus.col !== exp || {bus.key_valid, bus.entry_valid, bus.err} !== 3'b000) begin
            errors++; $display("FAIL idle_cycle%0d col got=%b want=%b pulses=%b", n, bus.col, exp, {bus.key_valid, bus.entry_valid, bus.err});
         end
      end
   endtask

   task automatic test_bounce();
      bit kv = 1'b0;
      logic [3:0] nxt = 4'b1101;
      wait_col(4'b1101);
      force_line = 4'b1101;
      repeat (2) @(negedge clk);
      force_line = 4'hF;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.key_valid) kv = 1'b1;
         if (nxt == 4'b1101 && bus.col != 4'b1101) nxt = bus.col;
      end
      checks++;
      if (kv !== 1'b0) begin errors++; $display("FAIL bounce_key_valid got=1 want=0"); end
      checks++;
      if (nxt !== 4'b1011) begin errors++; $display("FAIL bounce_resume_col got=%b want=1011", nxt); end
   endtask

   task automatic test_entry();
      press_key(4'h1);
      checks++;
      if (s_code !== 4'h1 || s_regs !== 16'h1000 || s_cnt !== 3'd1) begin
         errors++; $display("FAIL entry_d1 got=%h/%h/%0d want=1/1000/1", s_code, s_regs, s_cnt);
      end
      press_key(4'h9);
      checks++;
      if (s_code !== 4'h9 || s_regs !== 16'h1900 || s_cnt !== 3'd2) begin
         errors++; $display("FAIL entry_d9 got=%h/%h/%0d want=9/1900/2", s_code, s_regs, s_cnt);
      end
      press_key(4'h0);
      checks++;
      if (s_code !== 4'h0 || s_regs !== 16'h1900 || s_cnt !== 3'd3) begin
         errors++; $display("FAIL entry_d0 got=%h/%h/%0d want=0/1900/3", s_code, s_regs, s_cnt);
      end
      press_key(4'hF);
      checks++;
      if (s_ev !== 1'b1 || s_eval !== 16'h1900 || s_elen !== 3'd3 || s_err !== 1'b0) begin
         errors++; $display("FAIL entry_commit got=%b/%h/%0d/%b want=1/1900/3/0", s_ev, s_eval, s_elen, s_err);
      end
      checks++;
      if (s_regs !== 16'h0000 || s_cnt !== 3'd0 || s_code !== 4'hF) begin
         errors++; $display("FAIL entry_clear got=%h/%0d/%h want=0000/0/f", s_regs, s_cnt, s_code);
      end
      checks++;
      if (bus.entry_value !== 16'h1900 || bus.entry_len !== 3'd3) begin
         errors++; $display("FAIL entry_hold got=%h/%0d want=1900/3", bus.entry_value, bus.entry_len);
      end
   endtask

   task automatic test_overflow();
      press_key(4'h1);
      press_key(4'h2);
      press_key(4'h3);
      press_key(4'h4);
      checks++;
      if (s_regs !== 16'h1234 || s_cnt !== 3'd4 || s_err !== 1'b0) begin
         errors++; $display("FAIL overflow_full got=%h/%0d/%b want=1234/4/0", s_regs, s_cnt, s_err);
      end
      press_key(4'h5);
      checks++;
      if (s_err !== 1'b1 || s_code !== 4'h5 || s_regs !== 16'h1234 || s_cnt !== 3'd4) begin
         errors++; $display("FAIL overflow_fifth got=%b/%h/%h/%0d want=1/5/1234/4", s_err, s_code, s_regs, s_cnt);
      end
      press_key(4'hE);
      checks++;
      if (s_regs !== 16'h0000 || s_cnt !== 3'd0 || s_code !== 4'hE || s_err !== 1'b0 || s_ev !== 1'b0) begin
         errors++; $display("FAIL overflow_star got=%h/%0d/%h/%b/%b want=0000/0/e/0/0", s_regs, s_cnt, s_code, s_err, s_ev);
      end
   endtask

   task automatic test_empty_commit();
      press_key(4'hF);
      checks++;
      if (s_err !== 1'b1 || s_ev !== 1'b0 || s_eval !== 16'h1900 || s_elen !== 3'd3) begin
         errors++; $display("FAIL empty_hash got=%b/%b/%h/%0d want=1/0/1900/3", s_err, s_ev, s_eval, s_elen);
      end
      press_key(4'hB);
      checks++;
      if (s_code !== 4'hB || s_err !== 1'b0 || s_ev !== 1'b0 || s_regs !== 16'h0000 || s_cnt !== 3'd0) begin
         errors++; $display("FAIL letter_b got=%h/%b/%b/%h/%0d want=b/0/0/0000/0", s_code, s_err, s_ev, s_regs, s_cnt);
      end
   endtask

   task automatic test_reset_mid_press();
      bit kv = 1'b0;
      press_key(4'h1);
      press_key(4'h2);
      checks++;
      if (s_cnt !== 3'd2 || s_regs !== 16'h1200) begin
         errors++; $display("FAIL midreset_setup got=%h/%0d want=1200/2", s_regs, s_cnt);
      end
      start_press(4'h3);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.col !== 4'b1110 || bus.digit_count !== 3'd0 || {bus.reg1, bus.reg2, bus.reg3, bus.reg4} !== 16'h0000) begin
         errors++; $display("FAIL midreset_state got=%b/%0d/%h want=1110/0/0000", bus.col, bus.digit_count, {bus.reg1, bus.reg2, bus.reg3, bus.reg4});
      end
      reset = 1'b0;
      pressed = 1'b0;
      for (int i = 0; i < 25; i++) begin @(negedge clk); if (bus.key_valid) kv = 1'b1; end
      checks++;
      if (kv !== 1'b0) begin errors++; $display("FAIL midreset_release got=1 want=0"); end
      press_key(4'h7);
      checks++;
      if (s_code !== 4'h7 || s_regs !== 16'h7000 || s_cnt !== 3'd1) begin
         errors++; $display("FAIL midreset_recover got=%h/%h/%0d want=7/7000/1", s_code, s_regs, s_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_bounce();
      test_entry();
      test_overflow();
      test_empty_commit();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
